// File: rtl/sddr_phy_pkg.sv
// Shared types, constants and the latency clamp used by the SDDR PHY burst sequencer.
package sddr_phy_pkg;

  localparam int SDDR_DATA_BITS = 16;
  localparam int SDDR_MAX_LAT   = 15;
  localparam int LAT_BITS       = $clog2(SDDR_MAX_LAT + 1);

  typedef logic [2*SDDR_DATA_BITS-1:0] sddr_pair_t;

  typedef logic [2:0] sddr_burst_state_t;
  localparam sddr_burst_state_t ST_IDLE   = 3'd0;
  localparam sddr_burst_state_t ST_W_LAT  = 3'd1;
  localparam sddr_burst_state_t ST_W_PRE  = 3'd2;
  localparam sddr_burst_state_t ST_W_DATA = 3'd3;
  localparam sddr_burst_state_t ST_W_POST = 3'd4;
  localparam sddr_burst_state_t ST_R_LAT  = 3'd5;
  localparam sddr_burst_state_t ST_R_DATA = 3'd6;
  localparam sddr_burst_state_t ST_GAP    = 3'd7;

  // Raw value carries one extra bit so cl + rd_delay cannot wrap before saturation.
  function automatic logic [LAT_BITS-1:0] clamp_lat(input logic [LAT_BITS:0] raw,
                                                     input logic [LAT_BITS:0] lo,
                                                     input logic [LAT_BITS:0] hi);
    logic [LAT_BITS:0] v;
    v = raw;
    if (v < lo) v = lo;
    if (v > hi) v = hi;
    return v[LAT_BITS-1:0];
  endfunction

endpackage

// File: rtl/sddr_lat_counter.sv
// Loadable down-counter with a zero flag; times the latency and bus-turnaround phases.
module sddr_lat_counter
  import sddr_phy_pkg::*;
#(
  parameter int WIDTH = LAT_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load has priority; the count parks at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sddr_phy_burst_seq.sv
// PHY-side burst sequencer: counts CWL/CL itself and frames DQ/DQS enables, write requests and read capture.
module sddr_phy_burst_seq
  import sddr_phy_pkg::*;
#(
  parameter int DATA_BITS  = SDDR_DATA_BITS,
  parameter int BURST_LEN  = 8,
  parameter int MAX_LAT    = SDDR_MAX_LAT,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   in_ddr_clock_i,
  input  logic                   in_phy_reset_i,
  input  logic [LAT_BITS-1:0]    cfg_cwl_i,
  input  logic [LAT_BITS-1:0]    cfg_cl_i,
  input  logic [LAT_BITS-1:0]    cfg_rd_delay_i,
  input  logic                   cmd_valid_i,
  input  logic                   cmd_write_i,
  output logic                   cmd_ready_o,
  output logic                   wr_data_req_o,
  input  logic [2*DATA_BITS-1:0] ctl_dq_i,
  output logic                   rd_valid_o,
  output logic                   rd_last_o,
  output logic [2*DATA_BITS-1:0] rd_data_o,
  output logic [2*DATA_BITS-1:0] phy_dq_o,
  output logic                   phy_dq_oe_o,
  output logic                   phy_dqs_oe_o,
  output logic                   phy_dqs_pre_o,
  input  logic [2*DATA_BITS-1:0] phy_dq_i
);

  localparam int PAIR_BITS = 2 * DATA_BITS;
  localparam int BEATS     = BURST_LEN / 2;
  localparam int BEAT_BITS = $clog2(BEATS + 1);
  localparam int GAP_BITS  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int CNT_BITS  = (LAT_BITS > GAP_BITS) ? LAT_BITS : GAP_BITS;

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
  localparam logic [CNT_BITS-1:0]  GAP_LOAD  = CNT_BITS'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LAT_BITS:0]    LAT_MAX_W = (LAT_BITS + 1)'(MAX_LAT);

  sddr_burst_state_t    state_q, state_d;
  logic [BEAT_BITS-1:0] beat_q, beat_d;

  logic                 cmd_ready_q, cmd_ready_d;
  logic                 wr_data_req_q, wr_data_req_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_last_q, rd_last_d;
  logic [PAIR_BITS-1:0] rd_data_q, rd_data_d;
  logic [PAIR_BITS-1:0] phy_dq_q, phy_dq_d;
  logic                 phy_dq_oe_q, phy_dq_oe_d;
  logic                 phy_dqs_oe_q, phy_dqs_oe_d;
  logic                 phy_dqs_pre_q, phy_dqs_pre_d;

  logic                 cnt_load;
  logic [CNT_BITS-1:0]  cnt_load_val;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic                 enter_gap;

  logic [LAT_BITS-1:0]  cwl_lat;
  logic [LAT_BITS-1:0]  rl_lat;

  assign cwl_lat = clamp_lat({1'b0, cfg_cwl_i}, (LAT_BITS + 1)'(2), LAT_MAX_W);
  assign rl_lat  = clamp_lat({1'b0, cfg_cl_i} + {1'b0, cfg_rd_delay_i},
                             (LAT_BITS + 1)'(1), LAT_MAX_W);

  sddr_lat_counter #(
    .WIDTH(CNT_BITS)
  ) u_lat_counter (
    .clk       (in_ddr_clock_i),
    .rst       (in_phy_reset_i),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  // Write latency loads cwl-2 so W_LAT spans cycles 0..cwl-2; read loads rl so capture starts after cycle rl.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    enter_gap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          cnt_load = 1'b1;
          if (cmd_write_i) begin
            state_d      = ST_W_LAT;
            cnt_load_val = CNT_BITS'(cwl_lat) - CNT_BITS'(2);
          end else begin
            state_d      = ST_R_LAT;
            cnt_load_val = CNT_BITS'(rl_lat);
          end
        end
      end
      ST_W_LAT: begin
        if (cnt_zero) state_d = ST_W_PRE;
        else          cnt_dec = 1'b1;
      end
      ST_W_PRE: begin
        state_d = ST_W_DATA;
        beat_d  = '0;
      end
      ST_W_DATA: begin
        if (beat_q == LAST_BEAT) state_d = ST_W_POST;
        else                     beat_d  = beat_q + BEAT_BITS'(1);
      end
      ST_W_POST: begin
        enter_gap = 1'b1;
      end
      ST_R_LAT: begin
        if (cnt_zero) begin
          state_d = ST_R_DATA;
          beat_d  = '0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_R_DATA: begin
        if (beat_q == LAST_BEAT) enter_gap = 1'b1;
        else                     beat_d    = beat_q + BEAT_BITS'(1);
      end
      ST_GAP: begin
        if (cnt_zero) state_d = ST_IDLE;
        else          cnt_dec = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (enter_gap) begin
      if (GAP_CYCLES == 0) begin
        state_d = ST_IDLE;
      end else begin
        state_d      = ST_GAP;
        cnt_load     = 1'b1;
        cnt_load_val = GAP_LOAD;
      end
    end
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    cmd_ready_d   = (state_d == ST_IDLE);
    wr_data_req_d = (state_d == ST_W_PRE) || ((state_d == ST_W_DATA) && (beat_d != LAST_BEAT));
    phy_dq_oe_d   = (state_d == ST_W_DATA);
    phy_dqs_oe_d  = (state_d == ST_W_PRE) || (state_d == ST_W_DATA) || (state_d == ST_W_POST);
    phy_dqs_pre_d = (state_d == ST_W_PRE);
    phy_dq_d      = (state_d == ST_W_DATA) ? ctl_dq_i : '0;
    rd_valid_d    = (state_d == ST_R_DATA);
    rd_last_d     = (state_d == ST_R_DATA) && (beat_d == LAST_BEAT);
    rd_data_d     = (state_d == ST_R_DATA) ? phy_dq_i : rd_data_q;
  end

  always_ff @(posedge in_ddr_clock_i) begin
    if (in_phy_reset_i) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      cmd_ready_q   <= 1'b0;
      wr_data_req_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      rd_data_q     <= '0;
      phy_dq_q      <= '0;
      phy_dq_oe_q   <= 1'b0;
      phy_dqs_oe_q  <= 1'b0;
      phy_dqs_pre_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      cmd_ready_q   <= cmd_ready_d;
      wr_data_req_q <= wr_data_req_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
      rd_data_q     <= rd_data_d;
      phy_dq_q      <= phy_dq_d;
      phy_dq_oe_q   <= phy_dq_oe_d;
      phy_dqs_oe_q  <= phy_dqs_oe_d;
      phy_dqs_pre_q <= phy_dqs_pre_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign wr_data_req_o = wr_data_req_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_last_o     = rd_last_q;
  assign rd_data_o     = rd_data_q;
  assign phy_dq_o      = phy_dq_q;
  assign phy_dq_oe_o   = phy_dq_oe_q;
  assign phy_dqs_oe_o  = phy_dqs_oe_q;
  assign phy_dqs_pre_o = phy_dqs_pre_q;

endmodule

// File: tb/tb_sddr_phy_burst_seq.sv
// Bench for sddr_phy_burst_seq: cycle-offset model of each accepted burst plus directed literal checks.
module tb_sddr_phy_burst_seq;
  import sddr_phy_pkg::*;

  localparam int DATA_BITS  = 16;
  localparam int BURST_LEN  = 8;
  localparam int MAX_LAT    = 15;
  localparam int GAP_CYCLES = 2;
  localparam int BEATS      = BURST_LEN / 2;

  logic                clk;
  logic                reset;
  logic [LAT_BITS-1:0] cfg_cwl;
  logic [LAT_BITS-1:0] cfg_cl;
  logic [LAT_BITS-1:0] cfg_rd_delay;
  logic                cmd_valid;
  logic                cmd_write;
  logic                cmd_ready_o;
  logic                wr_data_req_o;
  sddr_pair_t          ctl_dq;
  logic                rd_valid_o;
  logic                rd_last_o;
  sddr_pair_t          rd_data_o;
  sddr_pair_t          phy_dq_o;
  logic                phy_dq_oe_o;
  logic                phy_dqs_oe_o;
  logic                phy_dqs_pre_o;
  sddr_pair_t          phy_dq_in;

  int checks   = 0;
  int failures = 0;

  sddr_phy_burst_seq #(
    .DATA_BITS (DATA_BITS),
    .BURST_LEN (BURST_LEN),
    .MAX_LAT   (MAX_LAT),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .in_ddr_clock_i(clk),
    .in_phy_reset_i(reset),
    .cfg_cwl_i     (cfg_cwl),
    .cfg_cl_i      (cfg_cl),
    .cfg_rd_delay_i(cfg_rd_delay),
    .cmd_valid_i   (cmd_valid),
    .cmd_write_i   (cmd_write),
    .cmd_ready_o   (cmd_ready_o),
    .wr_data_req_o (wr_data_req_o),
    .ctl_dq_i      (ctl_dq),
    .rd_valid_o    (rd_valid_o),
    .rd_last_o     (rd_last_o),
    .rd_data_o     (rd_data_o),
    .phy_dq_o      (phy_dq_o),
    .phy_dq_oe_o   (phy_dq_oe_o),
    .phy_dqs_oe_o  (phy_dqs_oe_o),
    .phy_dqs_pre_o (phy_dqs_pre_o),
    .phy_dq_i      (phy_dq_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: one burst at a time, described by its offset from the accept edge.
  int  cyc       = 0;
  int  m_acc_cyc = 0;
  int  m_k       = 0;
  int  m_cwl     = 2;
  int  m_rl      = 1;
  int  m_end     = 0;
  bit  m_busy    = 1'b0;
  bit  m_wr      = 1'b0;
  bit  m_ready   = 1'b0;
  bit  m_init    = 1'b0;

  logic       exp_ready, exp_wr_req, exp_dqs_pre, exp_dq_oe, exp_dqs_oe;
  logic       exp_rd_valid, exp_rd_last;
  sddr_pair_t exp_phy_dq;
  sddr_pair_t exp_rd_data = '0;

  function automatic int clampLat(int raw, int lo);
    int v;
    v = raw;
    if (v < lo) v = lo;
    if (v > MAX_LAT) v = MAX_LAT;
    return v;
  endfunction

  function automatic sddr_pair_t pairFor(int j);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'(j * 32'h1111);
    hi = 16'((j + 1) * 32'h1111);
    return {hi, lo};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_init  = 1'b1;
      m_busy  = 1'b0;
      m_ready = 1'b0;
      m_k     = 0;
    end else begin
      if (m_ready && cmd_valid) begin
        m_busy    = 1'b1;
        m_wr      = cmd_write;
        m_k       = 0;
        m_acc_cyc = cyc;
        m_cwl     = clampLat(int'(cfg_cwl), 2);
        m_rl      = clampLat(int'(cfg_cl) + int'(cfg_rd_delay), 1);
        m_end     = (m_wr ? m_cwl : m_rl) + BEATS + GAP_CYCLES + 1;
      end else if (m_busy) begin
        m_k++;
        if (m_k >= m_end) m_busy = 1'b0;
      end
      m_ready = !m_busy;
    end
    exp_ready    = m_ready;
    exp_wr_req   = m_busy && m_wr && (m_k >= m_cwl - 1) && (m_k <= m_cwl + BEATS - 2);
    exp_dqs_pre  = m_busy && m_wr && (m_k == m_cwl - 1);
    exp_dq_oe    = m_busy && m_wr && (m_k >= m_cwl) && (m_k <= m_cwl + BEATS - 1);
    exp_dqs_oe   = m_busy && m_wr && (m_k >= m_cwl - 1) && (m_k <= m_cwl + BEATS);
    exp_phy_dq   = exp_dq_oe ? ctl_dq : '0;
    exp_rd_valid = m_busy && !m_wr && (m_k >= m_rl + 1) && (m_k <= m_rl + BEATS);
    exp_rd_last  = m_busy && !m_wr && (m_k == m_rl + BEATS);
    if (reset) exp_rd_data = '0;
    else if (exp_rd_valid) exp_rd_data = phy_dq_in;
  end

  // Controller side: present the next pair whenever the model says a word is requested.
  always @(posedge clk) begin
    #2;
    if (exp_wr_req) ctl_dq = pairFor(m_k - (m_cwl - 1));
    else            ctl_dq = 32'hA5A5_5A5A;
    phy_dq_in = sddr_pair_t'(cyc - m_acc_cyc);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      checkOutput("cmd_ready_o",   64'(cmd_ready_o),   64'(exp_ready));
      checkOutput("wr_data_req_o", 64'(wr_data_req_o), 64'(exp_wr_req));
      checkOutput("phy_dqs_pre_o", 64'(phy_dqs_pre_o), 64'(exp_dqs_pre));
      checkOutput("phy_dq_oe_o",   64'(phy_dq_oe_o),   64'(exp_dq_oe));
      checkOutput("phy_dqs_oe_o",  64'(phy_dqs_oe_o),  64'(exp_dqs_oe));
      checkOutput("phy_dq_o",      64'(phy_dq_o),      64'(exp_phy_dq));
      checkOutput("rd_valid_o",    64'(rd_valid_o),    64'(exp_rd_valid));
      checkOutput("rd_last_o",     64'(rd_last_o),     64'(exp_rd_last));
      checkOutput("rd_data_o",     64'(rd_data_o),     64'(exp_rd_data));
    end
  end

  task automatic waitReady();
    int n;
    n = 0;
    while (!m_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!m_ready) begin
      failures++;
      $display("[TB] FAIL wait_ready: actual=busy required=idle within 500 cycles");
    end
  endtask

  // Issue one command; returns one time unit into cycle 0 of the accepted burst.
  task automatic applyStimulus(input bit wr, input int cwl, input int cl, input int dly);
    waitReady();
    cfg_cwl      = LAT_BITS'(cwl);
    cfg_cl       = LAT_BITS'(cl);
    cfg_rd_delay = LAT_BITS'(dly);
    cmd_write    = wr;
    cmd_valid    = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    cfg_cwl      = 4'hF;
    cfg_cl       = 4'hF;
    cfg_rd_delay = 4'hF;
  endtask

  task automatic gotoCycle(input int k);
    int n;
    n = 0;
    while ((cyc - m_acc_cyc) < k && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_write    = 1'b0;
    cfg_cwl      = '0;
    cfg_cl       = '0;
    cfg_rd_delay = '0;
    ctl_dq       = '0;
    phy_dq_in    = '0;
    $display("[TB] start");

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready_low", 64'(cmd_ready_o), 64'd0);
    checkOutput("rst_dqs_oe_low", 64'(phy_dqs_oe_o), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 64'(cmd_ready_o), 64'd1);
    checkOutput("idle_wr_req", 64'(wr_data_req_o), 64'd0);

    applyStimulus(1'b1, 5, 0, 0);
    gotoCycle(3);
    checkOutput("w5_c3_req", 64'(wr_data_req_o), 64'd0);
    gotoCycle(4);
    checkOutput("w5_c4_req", 64'(wr_data_req_o), 64'd1);
    checkOutput("w5_c4_pre", 64'(phy_dqs_pre_o), 64'd1);
    checkOutput("w5_c4_dqs", 64'(phy_dqs_oe_o), 64'd1);
    gotoCycle(5);
    checkOutput("w5_c5_dq", 64'(phy_dq_o), 64'h1111_0000);
    checkOutput("w5_c5_oe", 64'(phy_dq_oe_o), 64'd1);
    gotoCycle(7);
    checkOutput("w5_c7_req", 64'(wr_data_req_o), 64'd1);
    gotoCycle(8);
    checkOutput("w5_c8_dq", 64'(phy_dq_o), 64'h4444_3333);
    checkOutput("w5_c8_req", 64'(wr_data_req_o), 64'd0);
    gotoCycle(9);
    checkOutput("w5_c9_dqs", 64'(phy_dqs_oe_o), 64'd1);
    checkOutput("w5_c9_oe", 64'(phy_dq_oe_o), 64'd0);
    gotoCycle(11);
    checkOutput("w5_c11_ready", 64'(cmd_ready_o), 64'd0);
    gotoCycle(12);
    checkOutput("w5_c12_ready", 64'(cmd_ready_o), 64'd1);

    applyStimulus(1'b0, 0, 6, 2);
    gotoCycle(8);
    checkOutput("r8_c8_valid", 64'(rd_valid_o), 64'd0);
    gotoCycle(9);
    checkOutput("r8_c9_valid", 64'(rd_valid_o), 64'd1);
    checkOutput("r8_c9_data", 64'(rd_data_o), 64'd8);
    gotoCycle(12);
    checkOutput("r8_c12_data", 64'(rd_data_o), 64'd11);
    checkOutput("r8_c12_last", 64'(rd_last_o), 64'd1);
    gotoCycle(13);
    checkOutput("r8_c13_valid", 64'(rd_valid_o), 64'd0);
    checkOutput("r8_c13_hold", 64'(rd_data_o), 64'd11);

    applyStimulus(1'b1, 0, 0, 0);
    gotoCycle(1);
    checkOutput("cwl0_c1_pre", 64'(phy_dqs_pre_o), 64'd1);
    gotoCycle(2);
    checkOutput("cwl0_c2_oe", 64'(phy_dq_oe_o), 64'd1);

    applyStimulus(1'b0, 0, 0, 0);
    gotoCycle(1);
    checkOutput("rl0_c1_valid", 64'(rd_valid_o), 64'd0);
    gotoCycle(2);
    checkOutput("rl0_c2_data", 64'(rd_data_o), 64'd1);
    gotoCycle(5);
    checkOutput("rl0_c5_last", 64'(rd_last_o), 64'd1);

    applyStimulus(1'b0, 0, 12, 12);
    gotoCycle(15);
    checkOutput("rl24_c15_valid", 64'(rd_valid_o), 64'd0);
    gotoCycle(16);
    checkOutput("rl24_c16_data", 64'(rd_data_o), 64'd15);
    gotoCycle(19);
    checkOutput("rl24_c19_last", 64'(rd_last_o), 64'd1);

    applyStimulus(1'b1, 5, 0, 0);
    gotoCycle(6);
    checkOutput("abort_c6_oe", 64'(phy_dq_oe_o), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_oe", 64'(phy_dq_oe_o), 64'd0);
    checkOutput("abort_dqs", 64'(phy_dqs_oe_o), 64'd0);
    checkOutput("abort_req", 64'(wr_data_req_o), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", 64'(cmd_ready_o), 64'd1);
    checkOutput("abort_last", 64'(rd_last_o), 64'd0);

    waitReady();
    cfg_cwl      = 4'd2;
    cfg_cl       = 4'd3;
    cfg_rd_delay = 4'd0;
    cmd_write    = 1'b1;
    cmd_valid    = 1'b1;
    @(posedge clk);
    #1;
    cmd_write = 1'b0;
    gotoCycle(7);
    checkOutput("b2b_c7_dqs", 64'(phy_dqs_oe_o), 64'd0);
    checkOutput("b2b_c7_ready", 64'(cmd_ready_o), 64'd0);
    gotoCycle(8);
    checkOutput("b2b_c8_oe", 64'(phy_dq_oe_o), 64'd0);
    checkOutput("b2b_c8_ready", 64'(cmd_ready_o), 64'd0);
    gotoCycle(9);
    checkOutput("b2b_c9_ready", 64'(cmd_ready_o), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_rd_accepted", 64'(cmd_ready_o), 64'd0);
    gotoCycle(4);
    checkOutput("b2b_rd_data", 64'(rd_data_o), 64'd3);
    gotoCycle(7);
    checkOutput("b2b_rd_last", 64'(rd_last_o), 64'd1);

    waitReady();
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
